fun_inv: RTL and testbench

FUN_INV -- requirements
Module: fun_inv

---
 rtl/fun_pkg.sv | 19 +
 rtl/fun_inv_if.sv | 16 +
 rtl/fun_inv_mul8.sv | 57 +++++
 rtl/fun_inv.sv | 118 +++++++++++
 tb/tb_fun_inv.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/fun_pkg.sv
// Shared constants and state encoding for the fun_inv datapath and its
// multiplier.
package fun_pkg;

    localparam int          OP_W    = 8;
    localparam logic [3:0]  MUL_CYC = 4'd9;
    localparam logic [7:0]  D_MAX   = 8'd6;
    localparam logic [7:0]  SAT_VAL = 8'd255;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ   = 3'd1,
        SUB  = 3'd2,
        CU1  = 3'd3,
        CU2  = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage

// File: rtl/fun_inv_if.sv
// Request/result bundle of fun_inv: the requester drives start and the
// operands, the block returns busy and the registered result.
interface fun_inv_if;
    import fun_pkg::*;

    logic            start_i;
    logic [OP_W-1:0] a_bi;
    logic [OP_W-1:0] y_bi;
    logic            busy_o;
    logic [OP_W-1:0] b_bo;
    logic            ovf_o;

    modport master (output start_i, a_bi, y_bi, input busy_o, b_bo, ovf_o);
    modport slave  (input start_i, a_bi, y_bi, output busy_o, b_bo, ovf_o);

endinterface

// File: rtl/fun_inv_mul8.sv
// Sequential 8x8 unsigned shift-add multiplier: one partial product per
// cycle, busy for 8 cycles after start, product held until the next start.
module mul8
    import fun_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic              busy_o,
    output logic [2*OP_W-1:0] p_o
);

    logic [2*OP_W-1:0] acc_q, acc_d;
    logic [2*OP_W-1:0] mcand_q, mcand_d;
    logic [OP_W-1:0]   mplier_q, mplier_d;
    logic [3:0]        cnt_q, cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start_i && (cnt_q == 4'd0)) begin
            acc_d    = '0;
            mcand_d  = {{OP_W{1'b0}}, a_i};
            mplier_d = b_i;
            cnt_d    = 4'(OP_W);
        end else if (cnt_q != 4'd0) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != 4'd0);
    assign p_o    = acc_q;

endmodule

// File: rtl/fun_inv.sv
// Inverse of y = sqrt(a + cbrt(b)): b = (y*y - a)^3, built around one
// time-shared sequential multiplier.
module fun_inv
    import fun_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    fun_inv_if.slave  bus
);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [OP_W-1:0]   a_q, a_d, y_q, y_d, d_q, d_d;
    logic              under_q, under_d, sat_q, sat_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic              ovf_q, ovf_d;

    logic              mul_start, mul_busy;
    logic [OP_W-1:0]   mul_a, mul_b;
    logic [2*OP_W-1:0] prod;
    logic [2*OP_W:0]   diff;

    mul8 u_mul8 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mul_start),
        .a_i     (mul_a),
        .b_i     (mul_b),
        .busy_o  (mul_busy),
        .p_o     (prod)
    );

    // Top bit of diff is the borrow: set when a exceeds y*y.
    assign diff = {1'b0, prod} - {{(OP_W+1){1'b0}}, a_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        y_d       = y_q;
        d_d       = d_q;
        under_d   = under_q;
        sat_d     = sat_q;
        b_d       = b_q;
        ovf_d     = ovf_q;
        mul_start = 1'b0;
        mul_a     = y_q;
        mul_b     = y_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    a_d     = bus.a_bi;
                    y_d     = bus.y_bi;
                    cnt_d   = 4'd0;
                    state_d = SQ;
                end
            end
            SQ, CU1, CU2: begin
                if (state_q == CU1) begin
                    mul_a = d_q;
                    mul_b = d_q;
                end else if (state_q == CU2) begin
                    mul_a = prod[OP_W-1:0];
                    mul_b = d_q;
                end
                mul_start = (cnt_q == 4'd0) && !mul_busy;
                if (cnt_q == MUL_CYC - 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = (state_q == SQ)  ? SUB :
                              (state_q == CU1) ? CU2 : DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SUB: begin
                d_d     = diff[OP_W-1:0];
                under_d = diff[2*OP_W];
                sat_d   = !diff[2*OP_W] && (diff[2*OP_W-1:0] > {{OP_W{1'b0}}, D_MAX});
                state_d = (under_d || sat_d) ? DONE : CU1;
            end
            DONE: begin
                b_d     = under_q ? '0 : (sat_q ? SAT_VAL : prod[OP_W-1:0]);
                ovf_d   = under_q | sat_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            y_q     <= '0;
            d_q     <= '0;
            under_q <= 1'b0;
            sat_q   <= 1'b0;
            b_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            y_q     <= y_d;
            d_q     <= d_d;
            under_q <= under_d;
            sat_q   <= sat_d;
            b_q     <= b_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy_o = (state_q != IDLE);
    assign bus.b_bo   = b_q;
    assign bus.ovf_o  = ovf_q;

endmodule

// File: tb/tb_fun_inv.sv
// Randomized and directed checks of fun_inv against a plain-arithmetic
// model of b = (y*y - a)^3 with its underflow/saturation rules and latencies.
module tb_fun_inv;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    fun_inv_if bus ();

    fun_inv dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int last_b   = 0;
    int last_ovf = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void ref_model(input int a, input int y,
                                      output int b, output int ovf, output int busy);
        int sq;
        int d;
        sq = y * y;
        if (a > sq) begin
            b = 0; ovf = 1; busy = 11;
        end else begin
            d = sq - a;
            if (d > 6) begin
                b = 255; ovf = 1; busy = 11;
            end else begin
                b = d * d * d; ovf = 0; busy = 29;
            end
        end
    endfunction

    // Count busy cycles; meanwhile the result must hold and the inputs are
    // scrambled (including start) to show they are ignored.
    task automatic wait_busy(input string tag, input int inject_at, output int cnt);
        cnt = 0;
        while (bus.busy_o && cnt < 100) begin
            cnt++;
            check_eq({tag, "_hold_b"}, int'(bus.b_bo), last_b);
            if (cnt == inject_at) begin
                bus.start_i = 1'b1;
                bus.a_bi    = 8'd250;
                bus.y_bi    = 8'd16;
            end else begin
                bus.start_i = 1'($urandom_range(0, 1));
                bus.a_bi    = 8'($urandom);
                bus.y_bi    = 8'($urandom);
            end
            @(negedge clk_i);
        end
        bus.start_i = 1'b0;
    endtask

    task automatic run_op(input int a, input int y, input string tag, input int inject_at);
        int eb, eo, ebusy, cnt;
        ref_model(a, y, eb, eo, ebusy);
        @(negedge clk_i);
        bus.start_i = 1'b1;
        bus.a_bi    = a[7:0];
        bus.y_bi    = y[7:0];
        @(negedge clk_i);
        wait_busy(tag, inject_at, cnt);
        check_eq({tag, "_busy"}, cnt, ebusy);
        check_eq({tag, "_b"}, int'(bus.b_bo), eb);
        check_eq({tag, "_ovf"}, int'(bus.ovf_o), eo);
        last_b   = eb;
        last_ovf = eo;
        $display("op %s a=%0d y=%0d -> b=%0d ovf=%0d busy=%0d (model b=%0d ovf=%0d busy=%0d)",
                 tag, a, y, bus.b_bo, bus.ovf_o, cnt, eb, eo, ebusy);
    endtask

    initial begin
        int cnt, idle, a, y, k;
        bus.start_i = 1'b1;
        bus.a_bi    = 8'd5;
        bus.y_bi    = 8'd3;
        repeat (3) @(negedge clk_i);
        check_eq("rst_busy", int'(bus.busy_o), 0);
        check_eq("rst_b", int'(bus.b_bo), 0);
        check_eq("rst_ovf", int'(bus.ovf_o), 0);
        bus.start_i = 1'b0;
        rst_i = 1'b1;

        run_op(5,   3,   "y3a5",     0);
        run_op(250, 16,  "y16a250",  0);
        run_op(249, 16,  "y16a249",  0);
        run_op(5,   1,   "y1a5",     0);
        run_op(4,   2,   "y2a4",     0);
        run_op(0,   255, "y255a0",   0);
        run_op(5,   3,   "ignore2nd", 5);

        // Reset in the middle of an operation.
        @(negedge clk_i);
        bus.start_i = 1'b1; bus.a_bi = 8'd5; bus.y_bi = 8'd3;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        cnt = 0;
        while (bus.busy_o && cnt < 12) begin
            cnt++;
            @(negedge clk_i);
        end
        check_eq("pre_rst_busy", int'(bus.busy_o), 1);
        rst_i = 1'b0;
        #1;
        check_eq("midrst_busy", int'(bus.busy_o), 0);
        check_eq("midrst_b", int'(bus.b_bo), 0);
        check_eq("midrst_ovf", int'(bus.ovf_o), 0);
        bus.start_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_eq("rst_nostart", int'(bus.busy_o), 0);
        bus.start_i = 1'b0;
        rst_i  = 1'b1;
        last_b = 0; last_ovf = 0;
        run_op(5, 3, "after_rst", 0);

        // Back-to-back with start held high: exactly one idle cycle between.
        @(negedge clk_i);
        bus.start_i = 1'b1; bus.a_bi = 8'd5; bus.y_bi = 8'd3;
        @(negedge clk_i);
        cnt = 0;
        while (bus.busy_o && cnt < 100) begin
            cnt++;
            @(negedge clk_i);
        end
        check_eq("b2b_busy1", cnt, 29);
        check_eq("b2b_b1", int'(bus.b_bo), 64);
        bus.a_bi = 8'd250; bus.y_bi = 8'd16;
        idle = 0;
        while (!bus.busy_o && idle < 10) begin
            idle++;
            @(negedge clk_i);
        end
        bus.start_i = 1'b0;
        check_eq("b2b_idle", idle, 1);
        last_b = 64; last_ovf = 0;
        cnt = 0;
        while (bus.busy_o && cnt < 100) begin
            cnt++;
            @(negedge clk_i);
        end
        check_eq("b2b_busy2", cnt, 29);
        check_eq("b2b_b2", int'(bus.b_bo), 216);
        $display("op b2b idle=%0d b=%0d", idle, bus.b_bo);
        last_b = 216;

        // Random operations biased toward small differences.
        for (int i = 0; i < 30; i++) begin
            if (i % 4 == 3) begin
                a = int'($urandom_range(0, 255));
                y = int'($urandom_range(0, 255));
            end else begin
                y = int'($urandom_range(0, 16));
                k = int'($urandom_range(0, 9));
                a = y * y - k;
                if (a < 0)   a = 0;
                if (a > 255) a = 255;
                if (k == 9)  a = int'($urandom_range(0, 255));
            end
            run_op(a, y, "rnd", 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
